// File: rtl/fpu_divsqrt_pkg.sv
// Shared types and constants for the FP64 divide/sqrt issue stage.
package fpu_divsqrt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam int          BIAS     = 1023;
    localparam logic [63:0] QNAN     = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] PINF     = 64'h7FF0_0000_0000_0000;
    localparam int          WD_WIDTH = 7;

    // zero means a true zero; sub means exponent 0 with a nonzero fraction,
    // which the issue stage treats as a signed zero.
    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
        logic sub;
        logic sign;
    } fp64_class_t;

endpackage

// File: rtl/fp64_classify.sv
// Combinational FP64 operand classifier.
module fp64_classify
    import fpu_divsqrt_pkg::*;
(
    input  logic [63:0] operand,
    output fp64_class_t cls
);

    logic [10:0] exp_field;
    logic [51:0] frac_field;
    logic        exp_ones;
    logic        frac_zero;

    assign exp_field  = operand[62:52];
    assign frac_field = operand[51:0];
    assign exp_ones   = (exp_field == 11'h7FF);
    assign frac_zero  = (frac_field == 52'd0);

    // Decode the exponent/fraction fields into operand categories.
    always_comb begin
        cls      = '0;
        cls.sign = operand[63];
        cls.zero = (exp_field == 11'd0) && frac_zero;
        cls.sub  = (exp_field == 11'd0) && !frac_zero;
        cls.inf  = exp_ones && frac_zero;
        cls.nan  = exp_ones && !frac_zero;
        cls.snan = exp_ones && !frac_zero && !frac_field[51];
    end

endmodule

// File: rtl/fdivsqrt_issue.sv
// Issue/sequencing stage in front of the iterative FP64 divide/sqrt core.
// Resolves special operands locally, otherwise launches the core and waits.
module fdivsqrt_issue #(
    parameter int WATCHDOG = 64,
    parameter int BIAS     = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        core_start,
    output logic        core_op,
    output logic [52:0] core_mant_a,
    output logic [52:0] core_mant_b,
    input  logic        core_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_special,
    output logic [63:0] rsp_special_val,
    output logic        rsp_sign,
    output logic [12:0] rsp_exp,
    output logic        rsp_sqrt_odd,
    output logic        rsp_nv,
    output logic        rsp_dz,
    output logic        rsp_err,
    output logic        busy
);

    import fpu_divsqrt_pkg::state_t;
    import fpu_divsqrt_pkg::S_IDLE;
    import fpu_divsqrt_pkg::S_LAUNCH;
    import fpu_divsqrt_pkg::S_WAIT;
    import fpu_divsqrt_pkg::S_RESP;
    import fpu_divsqrt_pkg::S_DRAIN;
    import fpu_divsqrt_pkg::fp64_class_t;
    import fpu_divsqrt_pkg::QNAN;
    import fpu_divsqrt_pkg::PINF;
    import fpu_divsqrt_pkg::WD_WIDTH;

    localparam logic signed [12:0]   BIAS_S   = 13'(BIAS);
    localparam logic [WD_WIDTH-1:0]  WD_LIMIT = WD_WIDTH'(WATCHDOG - 1);

    state_t state;
    state_t state_next;

    fp64_class_t cls_a;
    fp64_class_t cls_b;

    logic                accept;
    logic                handshake;
    logic                wd_expire;
    logic [WD_WIDTH-1:0] wd;

    logic                sp_hit;
    logic [63:0]         sp_val;
    logic                sp_nv;
    logic                sp_dz;
    logic                zero_a;
    logic                zero_b;
    logic                div_sign;

    logic signed [12:0]  exp_a_s;
    logic signed [12:0]  exp_b_s;
    logic signed [12:0]  div_exp;
    logic signed [12:0]  sq_unb;
    logic signed [12:0]  sq_even;
    logic signed [12:0]  sq_exp;
    logic                sq_odd;

    logic                op_r;
    logic [52:0]         mant_a_r;
    logic [52:0]         mant_b_r;
    logic                special_r;
    logic [63:0]         special_val_r;
    logic                sign_r;
    logic [12:0]         exp_r;
    logic                odd_r;
    logic                nv_r;
    logic                dz_r;
    logic                err_r;

    fp64_classify u_cls_a (.operand(req_a), .cls(cls_a));
    fp64_classify u_cls_b (.operand(req_b), .cls(cls_b));

    assign accept    = req_valid & req_ready;
    assign handshake = rsp_valid & rsp_ready;
    assign wd_expire = (wd >= WD_LIMIT);
    assign zero_a    = cls_a.zero | cls_a.sub;
    assign zero_b    = cls_b.zero | cls_b.sub;
    assign div_sign  = cls_a.sign ^ cls_b.sign;

    // Resolve special operand combinations that never need the core.
    always_comb begin
        sp_hit = 1'b0;
        sp_val = '0;
        sp_nv  = 1'b0;
        sp_dz  = 1'b0;
        if (!req_op) begin
            if (cls_a.nan | cls_b.nan) begin
                sp_hit = 1'b1;
                sp_val = QNAN;
                sp_nv  = cls_a.snan | cls_b.snan;
            end else if ((zero_a & zero_b) | (cls_a.inf & cls_b.inf)) begin
                sp_hit = 1'b1;
                sp_val = QNAN;
                sp_nv  = 1'b1;
            end else if (cls_a.inf) begin
                sp_hit = 1'b1;
                sp_val = {div_sign, PINF[62:0]};
            end else if (zero_b) begin
                sp_hit = 1'b1;
                sp_val = {div_sign, PINF[62:0]};
                sp_dz  = 1'b1;
            end else if (cls_b.inf | zero_a) begin
                sp_hit = 1'b1;
                sp_val = {div_sign, 63'd0};
            end
        end else begin
            if (cls_a.nan) begin
                sp_hit = 1'b1;
                sp_val = QNAN;
                sp_nv  = cls_a.snan;
            end else if (zero_a) begin
                sp_hit = 1'b1;
                sp_val = {cls_a.sign, 63'd0};
            end else if (cls_a.sign) begin
                sp_hit = 1'b1;
                sp_val = QNAN;
                sp_nv  = 1'b1;
            end else if (cls_a.inf) begin
                sp_hit = 1'b1;
                sp_val = PINF;
            end
        end
    end

    // Result exponent for divide and sqrt; sqrt halves an even unbiased exponent.
    always_comb begin
        exp_a_s = signed'({2'b00, req_a[62:52]});
        exp_b_s = signed'({2'b00, req_b[62:52]});
        div_exp = exp_a_s - exp_b_s + BIAS_S;
        sq_unb  = exp_a_s - BIAS_S;
        sq_odd  = sq_unb[0];
        sq_even = sq_unb - signed'({12'd0, sq_odd});
        sq_exp  = (sq_even >>> 1) + BIAS_S;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a flush kills whatever is in flight.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = sp_hit ? S_RESP : S_LAUNCH;
            end
            S_LAUNCH: begin
                state_next = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush)                      state_next = core_done ? S_IDLE : S_DRAIN;
                else if (core_done | wd_expire) state_next = S_RESP;
            end
            S_RESP: begin
                if (flush | handshake) state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (core_done | wd_expire) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Watchdog counts cycles spent in WAIT and DRAIN since the launch.
    always_ff @(posedge clk) begin
        if (reset)                                  wd <= '0;
        else if (state == S_LAUNCH)                 wd <= '0;
        else if (state == S_WAIT || state == S_DRAIN) wd <= wd + 1'b1;
    end

    // Operand and response registers: captured on accept, patched on watchdog expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r          <= 1'b0;
            mant_a_r      <= '0;
            mant_b_r      <= '0;
            special_r     <= 1'b0;
            special_val_r <= '0;
            sign_r        <= 1'b0;
            exp_r         <= '0;
            odd_r         <= 1'b0;
            nv_r          <= 1'b0;
            dz_r          <= 1'b0;
            err_r         <= 1'b0;
        end else if (accept) begin
            op_r          <= req_op;
            mant_a_r      <= {1'b1, req_a[51:0]};
            mant_b_r      <= req_op ? {1'b1, req_a[51:0]} : {1'b1, req_b[51:0]};
            special_r     <= sp_hit;
            special_val_r <= sp_val;
            sign_r        <= sp_hit ? sp_val[63] : (~req_op & div_sign);
            exp_r         <= sp_hit ? 13'd0 : (req_op ? sq_exp : div_exp);
            odd_r         <= ~sp_hit & req_op & sq_odd;
            nv_r          <= sp_nv;
            dz_r          <= sp_dz;
            err_r         <= 1'b0;
        end else if (state == S_WAIT && !flush && !core_done && wd_expire) begin
            special_r     <= 1'b1;
            special_val_r <= QNAN;
            err_r         <= 1'b1;
        end
    end

    // Drive outputs from state and registers, forced low while reset is held.
    always_comb begin
        req_ready       = (state == S_IDLE) & ~flush & ~reset;
        core_start      = (state == S_LAUNCH) & ~reset;
        core_op         = op_r & ~reset;
        core_mant_a     = reset ? 53'd0 : mant_a_r;
        core_mant_b     = reset ? 53'd0 : mant_b_r;
        rsp_valid       = (state == S_RESP) & ~flush & ~reset;
        rsp_special     = special_r & ~reset;
        rsp_special_val = reset ? 64'd0 : special_val_r;
        rsp_sign        = sign_r & ~reset;
        rsp_exp         = reset ? 13'd0 : exp_r;
        rsp_sqrt_odd    = odd_r & ~reset;
        rsp_nv          = nv_r & ~reset;
        rsp_dz          = dz_r & ~reset;
        rsp_err         = err_r & ~reset;
        busy            = (state != S_IDLE) & ~reset;
    end

endmodule

// File: tb/tb_fdivsqrt_issue.sv
// Scoreboard bench for fdivsqrt_issue with a behavioural core and reference model.
module tb_fdivsqrt_issue;

    localparam logic [63:0] T_QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct {
        bit          special;
        logic [63:0] val;
        bit          sign;
        logic [12:0] expo;
        bit          odd;
        bit          nv;
        bit          dz;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        bit          op;
        logic [52:0] ma;
        logic [52:0] mb;
        int          delay;
        int          acc;
    } core_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        core_start;
    logic        core_op;
    logic [52:0] core_mant_a;
    logic [52:0] core_mant_b;
    logic        core_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_special;
    logic [63:0] rsp_special_val;
    logic        rsp_sign;
    logic [12:0] rsp_exp;
    logic        rsp_sqrt_odd;
    logic        rsp_nv;
    logic        rsp_dz;
    logic        rsp_err;
    logic        busy;

    logic        done_model;
    logic        done_extra;
    bit          rand_bp;
    int          cyc;
    int          cd;
    int          checks;
    int          passed;

    exp_t        sq[$];
    core_t       cq[$];

    assign core_done = done_model | done_extra;

    fdivsqrt_issue #(.WATCHDOG(64), .BIAS(1023)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .core_start(core_start), .core_op(core_op),
        .core_mant_a(core_mant_a), .core_mant_b(core_mant_b), .core_done(core_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_special(rsp_special),
        .rsp_special_val(rsp_special_val), .rsp_sign(rsp_sign), .rsp_exp(rsp_exp),
        .rsp_sqrt_odd(rsp_sqrt_odd), .rsp_nv(rsp_nv), .rsp_dz(rsp_dz),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc++;

    // Global time guard so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act === want) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    endtask

    // Reference model straight from the FP rules: classify, pick special result or compute exponent.
    function automatic exp_t refModel(input bit op, input logic [63:0] a, input logic [63:0] b);
        exp_t r;
        int   ea = int'(a[62:52]);
        int   eb = int'(b[62:52]);
        bit   sa = a[63];
        bit   sb = b[63];
        bit   za = (ea == 0);
        bit   zb = (eb == 0);
        bit   ia = (ea == 2047) && (a[51:0] == 0);
        bit   ib = (eb == 2047) && (b[51:0] == 0);
        bit   na = (ea == 2047) && (a[51:0] != 0);
        bit   nb = (eb == 2047) && (b[51:0] != 0);
        bit   sna = na && !a[51];
        bit   snb = nb && !b[51];
        bit   s = sa ^ sb;
        int   e;
        r.special = 1; r.val = 0; r.sign = 0; r.expo = 0; r.odd = 0;
        r.nv = 0; r.dz = 0; r.err = 0; r.lat = 0; r.acc = 0;
        if (!op) begin
            if (na || nb) begin r.val = T_QNAN; r.nv = sna || snb; end
            else if ((za && zb) || (ia && ib)) begin r.val = T_QNAN; r.nv = 1; end
            else if (ia) r.val = {s, 11'h7FF, 52'd0};
            else if (zb) begin r.val = {s, 11'h7FF, 52'd0}; r.dz = 1; end
            else if (ib || za) r.val = {s, 63'd0};
            else begin
                r.special = 0;
                r.sign    = s;
                r.expo    = 13'(ea - eb + 1023);
            end
        end else begin
            if (na) begin r.val = T_QNAN; r.nv = sna; end
            else if (za) r.val = {sa, 63'd0};
            else if (sa) begin r.val = T_QNAN; r.nv = 1; end
            else if (ia) r.val = {1'b0, 11'h7FF, 52'd0};
            else begin
                r.special = 0;
                e         = ea - 1023;
                r.odd     = (e % 2 != 0);
                r.expo    = r.odd ? 13'((e - 1) / 2 + 1023) : 13'(e / 2 + 1023);
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] genOperand();
        int          k = $urandom_range(0, 19);
        logic        s = 1'($urandom_range(0, 1));
        logic [10:0] e = 11'($urandom_range(1, 2046));
        logic [51:0] f = {20'($urandom), $urandom};
        if (k == 12 || k == 13) begin e = 0; f = 0; end
        else if (k == 14) begin e = 0; f[0] = 1'b1; end
        else if (k == 15 || k == 16) begin e = 11'h7FF; f = 0; end
        else if (k == 17) begin e = 11'h7FF; f[51] = 1'b1; end
        else if (k == 18) begin e = 11'h7FF; f[51] = 1'b0; f[0] = 1'b1; end
        else if (k == 19) e = 11'($urandom_range(1000, 1050));
        return {s, e, f};
    endfunction

    // Issue one request; delay 0 means the core never answers.
    task automatic applyStimulus(input bit op, input logic [63:0] a, input logic [63:0] b,
                                 input int delay, input bit expect_rsp);
        exp_t  it;
        core_t ct;
        bit    normal;
        bit    took = 0;
        it     = refModel(op, a, b);
        normal = !it.special;
        if (normal && delay == 0) begin
            it.special = 1; it.val = T_QNAN; it.err = 1; it.nv = 0; it.dz = 0; it.lat = 66;
        end else if (normal) it.lat = delay + 2;
        else it.lat = 1;
        @(posedge clk); #1;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        for (int t = 0; t < 300 && !took; t++) begin
            @(negedge clk);
            if (req_ready) begin
                it.acc = cyc;
                if (expect_rsp) sq.push_back(it);
                if (normal) begin
                    ct.op = op; ct.ma = {1'b1, a[51:0]};
                    ct.mb = op ? {1'b1, a[51:0]} : {1'b1, b[51:0]};
                    ct.delay = delay; ct.acc = cyc;
                    cq.push_back(ct);
                end
                took = 1;
            end
        end
        if (!took) checkOutput("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 500 && sq.size() != 0; t++) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sq.size()), 0);
    endtask

    // Behavioural core: check the launch, then answer after the programmed delay.
    core_t cur;
    always @(negedge clk) begin
        if (!reset && core_start) begin
            if (cq.size() == 0) checkOutput("unexpected_core_start", 1, 0);
            else begin
                cur = cq.pop_front();
                checkOutput("core_mant_a", 64'(core_mant_a), 64'(cur.ma));
                checkOutput("core_mant_b", 64'(core_mant_b), 64'(cur.mb));
                checkOutput("core_op", 64'(core_op), 64'(cur.op));
                checkOutput("start_latency", 64'(cyc - cur.acc), 1);
                cd = cur.delay;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        done_model = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) done_model = 1'b1;
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on each response handshake and checks stability under stall.
    bit          pending;
    int          first_cyc;
    logic [63:0] snap_val;
    logic [19:0] snap_meta;
    exp_t        got;
    always @(negedge clk) begin
        if (reset) pending = 0;
        else if (rsp_valid) begin
            if (pending) begin
                checkOutput("stall_val_stable", rsp_special_val, snap_val);
                checkOutput("stall_meta_stable",
                            64'({rsp_special, rsp_sign, rsp_exp, rsp_sqrt_odd, rsp_nv, rsp_dz, rsp_err}),
                            64'(snap_meta));
            end else first_cyc = cyc;
            if (rsp_ready) begin
                pending = 0;
                if (sq.size() == 0) checkOutput("unexpected_rsp", 1, 0);
                else begin
                    got = sq.pop_front();
                    checkOutput("rsp_latency", 64'(first_cyc - got.acc), 64'(got.lat));
                    checkOutput("rsp_special", 64'(rsp_special), 64'(got.special));
                    checkOutput("rsp_nv", 64'(rsp_nv), 64'(got.nv));
                    checkOutput("rsp_dz", 64'(rsp_dz), 64'(got.dz));
                    checkOutput("rsp_err", 64'(rsp_err), 64'(got.err));
                    if (got.special) checkOutput("rsp_special_val", rsp_special_val, got.val);
                    else begin
                        checkOutput("rsp_sign", 64'(rsp_sign), 64'(got.sign));
                        checkOutput("rsp_exp", 64'(rsp_exp), 64'(got.expo));
                        checkOutput("rsp_sqrt_odd", 64'(rsp_sqrt_odd), 64'(got.odd));
                    end
                end
            end else begin
                pending   = 1;
                snap_val  = rsp_special_val;
                snap_meta = {rsp_special, rsp_sign, rsp_exp, rsp_sqrt_odd, rsp_nv, rsp_dz, rsp_err};
            end
        end else if (pending) begin
            checkOutput("rsp_valid_dropped", 0, 1);
            pending = 0;
        end
    end

    initial begin
        checks = 0; passed = 0; cyc = 0; cd = 0;
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 1'b0;
        req_a = '0; req_b = '0; done_model = 1'b0; done_extra = 1'b0;
        rsp_ready = 1'b1; rand_bp = 0;

        @(negedge clk);
        checkOutput("reset_req_ready", 64'(req_ready), 0);
        checkOutput("reset_busy", 64'(busy), 0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 0);
        checkOutput("reset_core_start", 64'(core_start), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_ready", 64'(req_ready), 1);

        $display("[TB] directed operations");
        applyStimulus(0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 11, 1);
        applyStimulus(0, 64'h3FF0_0000_0000_0000, 64'h0, 5, 1);
        applyStimulus(1, 64'hC010_0000_0000_0000, 64'h0, 5, 1);
        applyStimulus(1, 64'h4020_0000_0000_0000, 64'h0, 7, 1);
        waitDrain();

        $display("[TB] flush during wait");
        applyStimulus(0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 0);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (4) @(posedge clk);
        #1 done_extra = 1'b1;
        @(negedge clk);
        checkOutput("flush_ready_at_done", 64'(req_ready), 0);
        checkOutput("flush_busy_at_done", 64'(busy), 1);
        @(posedge clk); #1 done_extra = 1'b0;
        @(negedge clk);
        checkOutput("flush_ready_after_done", 64'(req_ready), 1);

        $display("[TB] backpressure then watchdog");
        rsp_ready = 1'b0;
        applyStimulus(0, 64'h3FF0_0000_0000_0000, 64'h0, 5, 1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_req_ready", 64'(req_ready), 0);
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 1);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        applyStimulus(0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 1);
        waitDrain();

        $display("[TB] reset during wait");
        applyStimulus(0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_req_ready", 64'(req_ready), 0);
        checkOutput("midreset_busy", 64'(busy), 0);
        checkOutput("midreset_core_mant_a", 64'(core_mant_a), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("postreset_busy", 64'(busy), 0);
        checkOutput("postreset_req_ready", 64'(req_ready), 1);
        checkOutput("postreset_special_val", rsp_special_val, 0);
        checkOutput("postreset_rsp_err", 64'(rsp_err), 0);
        @(posedge clk); #1 done_extra = 1'b1;
        @(posedge clk); #1 done_extra = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stray_done_busy", 64'(busy), 0);
            checkOutput("stray_done_rsp_valid", 64'(rsp_valid), 0);
        end

        $display("[TB] randomized operations");
        rand_bp = 1;
        for (int i = 0; i < 150; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            int          d;
            a = genOperand();
            b = genOperand();
            d = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 20);
            applyStimulus(1'($urandom_range(0, 1)), a, b, d, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        waitDrain();
        rand_bp = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fdivsqrt_issue.md
Name: fdivsqrt_issue

Overview:
Issue/sequencing stage that sits directly upstream of the iterative divide/sqrt control FSM and its datapath. It accepts FP64 divide or sqrt requests over a valid/ready handshake, classifies the operands, and resolves special cases locally without using the core. For normal operands it unpacks the mantissas, computes the result sign and exponent, pulses `start` to the iterative core, waits for `done`, and then presents result metadata downstream over a valid/ready handshake.

Parameters:
WATCHDOG, 64, maximum cycles spent in WAIT/DRAIN before the operation is abandoned.
BIAS, 1023, FP64 exponent bias.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  kill in-flight operation (pipeline flush)
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_op  in  1  0 = divide a/b, 1 = sqrt a (b ignored)
req_a  in  64  FP64 operand a
req_b  in  64  FP64 operand b
core_start  out  1  one-cycle start pulse to iterative core
core_op  out  1  op_type to core, valid in the core_start cycle
core_mant_a  out  53  {1, frac_a}, held from LAUNCH until core_done
core_mant_b  out  53  {1, frac_b}, held likewise (sqrt: equals core_mant_a)
core_done  in  1  core completion pulse
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts
rsp_special  out  1  result is rsp_special_val; core output not used
rsp_special_val  out  64  FP64 special result
rsp_sign  out  1  result sign
rsp_exp  out  13  biased result exponent, two's complement, before normalisation and rounding
rsp_sqrt_odd  out  1  sqrt unbiased exponent was odd
rsp_nv  out  1  invalid flag
rsp_dz  out  1  divide-by-zero flag
rsp_err  out  1  watchdog expiry
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LAUNCH, WAIT, RESP, DRAIN. Reset puts the FSM in IDLE.
- Output values:
  - During reset, all outputs are 0, including req_ready.
  - Response registers clear to 0 on reset.
- req_ready = (state == IDLE) & ~flush & ~reset.
- Accept, special operands: IDLE -> RESP. rsp_valid is asserted the cycle after accept. core_start is never asserted.
- Accept, normal operands: IDLE -> LAUNCH. Operands, sign, exponent and flags are registered on accept.
- LAUNCH: core_start = 1 and core_op = the registered op, for exactly one cycle. Next state is WAIT.
- WAIT:
  - core_done -> RESP, with rsp_valid asserted the next cycle.
  - Watchdog reaching WATCHDOG -> RESP with rsp_err=1, rsp_special=1, rsp_special_val = qNaN.
- RESP: all rsp_* outputs stay stable while rsp_valid & ~rsp_ready. The handshake moves the FSM to IDLE.
- Flush:
  - In LAUNCH, core_start is still pulsed that cycle; the FSM goes to DRAIN.
  - In WAIT -> DRAIN.
  - In RESP -> IDLE; the response is dropped.
  - In IDLE, no request is accepted.
- DRAIN: wait for core_done or watchdog expiry, discard the result, then go to IDLE. No rsp_valid is produced.
- core_done is ignored in IDLE, LAUNCH and RESP.
- Watchdog: an 7-bit counter. It clears on entry to WAIT/DRAIN and increments each cycle in those states. It does not reset on the WAIT -> DRAIN transition.
- Subnormal inputs are flushed to signed zero before classification.
- Divide:
  - sign = sa ^ sb
  - rsp_exp = ea - eb + BIAS
- Sqrt:
  - e = ea - BIAS
  - rsp_sqrt_odd = e[0]
  - rsp_exp = ((e - e[0]) >>> 1) + BIAS
  - sign = 0
- qNaN = 64'h7FF8_0000_0000_0000. Any sNaN input sets nv.
- Divide specials:
  - NaN operand -> qNaN.
  - 0/0 or inf/inf -> qNaN, nv.
  - finite nonzero / 0 -> signed inf, dz.
  - inf/finite -> signed inf.
  - finite/inf or 0/nonzero -> signed zero.
- Sqrt specials:
  - NaN -> qNaN.
  - Negative nonzero (including -inf) -> qNaN, nv.
  - ±0 -> ±0.
  - +inf -> +inf.

Decomposition:
- Package fpu_divsqrt_pkg holds:
  - the state enum;
  - the constants BIAS, QNAN, PINF;
  - a struct fp64_class_t {zero, inf, nan, snan, sub, sign}.
- One combinational sub-module, fp64_classify (operand -> fp64_class_t), instantiated once per operand.

Test Plan:
- div 0x4018000000000000 / 0x4000000000000000 -> core_start is asserted 1 cycle after accept, with core_mant_a = 0x18000000000000 and core_mant_b = 0x10000000000000. core_done arrives 11 cycles later. rsp_valid follows with rsp_exp = 0x400, rsp_sign = 0, rsp_special = 0.
- div 0x3FF0000000000000 / 0x0 -> rsp_valid 1 cycle after accept, rsp_special_val = 0x7FF0000000000000, rsp_dz = 1, core_start never asserted.
- sqrt 0xC010000000000000 -> rsp_special_val = 0x7FF8000000000000, rsp_nv = 1. sqrt 0x4020000000000000 -> rsp_exp = 0x400, rsp_sqrt_odd = 1.
- flush 3 cycles into WAIT, core_done 5 cycles later -> no rsp_valid; req_ready rises the cycle after core_done.
- rsp_ready held 0 for 3 cycles in RESP -> all rsp_* outputs stable, req_ready = 0. Then core_done is held low after a new launch -> after 64 cycles rsp_err = 1, rsp_special_val = qNaN.
- reset asserted mid-WAIT -> next cycle state IDLE, all outputs 0, and a stray core_done is ignored.
